// File: rtl/vblank_scheduler.sv
// vblank_scheduler: round-robin arbiter granting the vblank window to N_REQ requesters.
// Define VBLANK_SCHED_FIXED_PRIO_EN for fixed priority (index 0 highest).
module vblank_scheduler #(
  parameter int N_REQ    = 3,
  parameter int SLOT_MAX = 1024,
  parameter int FCNT_W   = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              vblnk,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  done,
  input  logic              err_clr,
  output logic [N_REQ-1:0]  grant,
  output logic              busy,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              timeout_err,
  output logic              overrun_err
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam logic [1:0] IDLE = 2'd0, ARB = 2'd1, GRANT = 2'd2, WAIT_END = 2'd3;
  logic [1:0] state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d, grant_q, grant_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, winner_q, winner_d, pick, nxt_ptr;
  logic [SW-1:0] slot_q, slot_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic vblnk_q, fstart_q, fstart_d, tmo_q, ovr_q, tmo_set, ovr_set;
  logic rise, fin;
  int idx;
  assign rise = vblnk & ~vblnk_q;
  assign fin = done[winner_q] || slot_q == SW'(SLOT_MAX - 1);
`ifdef VBLANK_SCHED_FIXED_PRIO_EN
  assign nxt_ptr = '0;
`else
  assign nxt_ptr = (winner_q == PW'(N_REQ - 1)) ? '0 : winner_q + PW'(1);
`endif
  // descending scan so the smallest offset from rr_ptr ends up as the winner
  always_comb begin
    pick = '0;
    idx = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      idx = (idx >= N_REQ) ? idx - N_REQ : idx;
      if (pending_q[PW'(idx)]) pick = PW'(idx);
    end
  end
  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    rr_ptr_d = rr_ptr_q;
    winner_d = winner_q;
    slot_d = slot_q;
    grant_d = grant_q;
    fcnt_d = fcnt_q;
    fstart_d = 1'b0;
    tmo_set = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        fstart_d = 1'b1;
        fcnt_d = fcnt_q + FCNT_W'(1);
        pending_d = req;
        state_d = ARB;
      end
      ARB: if (!vblnk) begin
        ovr_set = |pending_q;
        pending_d = '0;
        state_d = IDLE;
      end else if (pending_q == '0) begin
        state_d = WAIT_END;
      end else begin
        grant_d = N_REQ'(1) << pick;
        winner_d = pick;
        slot_d = '0;
        state_d = GRANT;
      end
      GRANT: if (!vblnk) begin
        grant_d = '0;
        ovr_set = 1'b1;
        pending_d = '0;
        state_d = IDLE;
      end else if (fin) begin
        grant_d = '0;
        pending_d[winner_q] = 1'b0;
        rr_ptr_d = nxt_ptr;
        tmo_set = ~done[winner_q];
        state_d = ARB;
      end else begin
        slot_d = slot_q + SW'(1);
      end
      default: state_d = vblnk ? WAIT_END : IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= '0;
      rr_ptr_q <= '0;
      winner_q <= '0;
      slot_q <= '0;
      grant_q <= '0;
      fcnt_q <= '0;
      fstart_q <= 1'b0;
      vblnk_q <= 1'b1;
      tmo_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      slot_q <= slot_d;
      grant_q <= grant_d;
      fcnt_q <= fcnt_d;
      fstart_q <= fstart_d;
      vblnk_q <= vblnk;
      tmo_q <= tmo_set | (tmo_q & ~err_clr);
      ovr_q <= ovr_set | (ovr_q & ~err_clr);
    end
  end
  assign grant = grant_q;
  assign busy = (state_q == ARB) || (state_q == GRANT);
  assign frame_start = fstart_q;
  assign frame_cnt = fcnt_q;
  assign timeout_err = tmo_q;
  assign overrun_err = ovr_q;
endmodule

// File: tb/tb_vblank_scheduler.sv
// tb_vblank_scheduler: directed frame-table and corner-sequence bench for vblank_scheduler.
// Expected orders follow VBLANK_SCHED_FIXED_PRIO_EN when it is defined.
module tb_vblank_scheduler;
  logic clk = 1'b0, rst = 1'b1, vblnk = 1'b1, err_clr = 1'b0;
  logic [2:0] req = '0, done = '0, grant;
  logic busy, frame_start, timeout_err, overrun_err;
  logic [7:0] frame_cnt, exp_fcnt;
  int checks = 0, failures = 0;
  typedef struct {
    logic [2:0] r;
    int dly;
    logic [8:0] ord;
    int n;
    int len;
    logic tmo;
  } vec_t;
  vec_t vecs[9];
`ifdef VBLANK_SCHED_FIXED_PRIO_EN
  localparam logic [8:0] O4 = 9'b000_001_100, O5 = 9'b001_010_100, O6 = 9'b000_001_100;
`else
  localparam logic [8:0] O4 = 9'b000_100_001, O5 = 9'b010_100_001, O6 = 9'b000_100_001;
`endif

  always #5 clk = ~clk;

  vblank_scheduler #(.N_REQ(3), .SLOT_MAX(16), .FCNT_W(8)) dut (
    .clk_in(clk), .rst(rst), .vblnk(vblnk), .req(req), .done(done), .err_clr(err_clr),
    .grant(grant), .busy(busy), .frame_start(frame_start), .frame_cnt(frame_cnt),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // one vblank frame: answer each grant with done after dly cycles (0 = never)
  task automatic run_frame(input logic [2:0] r, input int dly, output logic [8:0] ord,
                           output int n, output int len, output int fs, output int gaps);
    logic [2:0] prev;
    bit ended;
    req = r; vblnk = 1'b1; ord = '0; n = 0; len = 0; fs = 0; gaps = 0; prev = '0; ended = 0;
    for (int c = 0; c < 300 && !ended; c++) begin
      @(negedge clk);
      done = '0;
      if (frame_start) fs++;
      if (grant != '0) begin
        if (prev == '0) begin
          ord = {ord[5:0], grant};
          n++;
          len = 0;
        end else if (grant != prev) gaps++;
        len++;
        if (dly > 0 && len == dly) done = grant;
      end
      prev = grant;
      if (c > 0 && !busy) ended = 1;
    end
    chk("frame_end", ended, 1);
    vblnk = 1'b0; done = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [8:0] ord;
    int n, len, fs, gaps;
    bit hit;
    vecs[0] = '{3'b111, 5,  9'b001_010_100, 3, 5,  1'b0};
    vecs[1] = '{3'b011, 5,  9'b000_001_010, 2, 5,  1'b0};
    vecs[2] = '{3'b010, 0,  9'b000_000_010, 1, 16, 1'b1};
    vecs[3] = '{3'b010, 16, 9'b000_000_010, 1, 16, 1'b0};
    vecs[4] = '{3'b101, 3,  O4,             2, 3,  1'b0};
    vecs[5] = '{3'b111, 2,  O5,             3, 2,  1'b0};
    vecs[6] = '{3'b101, 4,  O6,             2, 4,  1'b0};
    vecs[7] = '{3'b101, 4,  O6,             2, 4,  1'b0};
    vecs[8] = '{3'b000, 3,  9'b000_000_000, 0, 0,  1'b0};
    exp_fcnt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fs = 0; n = 0;
    repeat (100) begin
      @(negedge clk);
      if (frame_start) fs++;
      if (grant != '0) n++;
    end
    chk("rst_no_frame", fs, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_grant_cycles", n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {timeout_err, overrun_err}, 0);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
    for (int v = 0; v < 9; v++) begin
      run_frame(vecs[v].r, vecs[v].dly, ord, n, len, fs, gaps);
      exp_fcnt++;
      chk($sformatf("v%0d_order", v), ord, vecs[v].ord);
      chk($sformatf("v%0d_ngrants", v), n, vecs[v].n);
      chk($sformatf("v%0d_grant_len", v), len, vecs[v].len);
      chk($sformatf("v%0d_frame_start", v), fs, 1);
      chk($sformatf("v%0d_gap", v), gaps, 0);
      chk($sformatf("v%0d_fcnt", v), frame_cnt, exp_fcnt);
      chk($sformatf("v%0d_timeout", v), timeout_err, vecs[v].tmo);
      chk($sformatf("v%0d_overrun", v), overrun_err, 0);
      if (vecs[v].tmo) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_tmo_clr", v), timeout_err, 0);
      end
    end
    // vblank ends while requester 1 holds the grant
    req = 3'b111; vblnk = 1'b1; hit = 0;
    exp_fcnt++;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      done = '0;
      if (grant == 3'b010) hit = 1;
      else if (grant != '0) done = grant;
    end
    chk("ovr_reach", hit, 1);
    vblnk = 1'b0;
    @(negedge clk);
    chk("ovr_grant", grant, 0);
    chk("ovr_flag", overrun_err, 1);
    chk("ovr_busy", busy, 0);
    chk("ovr_timeout", timeout_err, 0);
    repeat (3) @(negedge clk);
    chk("ovr_sticky", overrun_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovr_clr", overrun_err, 0);
    run_frame(3'b000, 1, ord, n, len, fs, gaps);
    exp_fcnt++;
    chk("post_ovr_ngrants", n, 0);
    chk("post_ovr_overrun", overrun_err, 0);
    // frame counter wrap
    hit = 0;
    for (int k = 0; k < 256 && !hit; k++) begin
      req = '0; vblnk = 1'b1;
      repeat (3) @(negedge clk);
      vblnk = 1'b0;
      repeat (3) @(negedge clk);
      exp_fcnt++;
      if (exp_fcnt == 8'd255) chk("fcnt_255", frame_cnt, 255);
      if (exp_fcnt == 8'd0) hit = 1;
    end
    chk("fcnt_wrap", frame_cnt, 0);
    chk("fcnt_wrap_done", hit, 1);
    // reset mid-grant with vblnk still high
    req = 3'b001; vblnk = 1'b1; hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (grant != '0) hit = 1;
    end
    chk("rstg_reach", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstg_grant", grant, 0);
    chk("rstg_fcnt", frame_cnt, 0);
    chk("rstg_busy", busy, 0);
    fs = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_start) fs++;
    end
    chk("rstg_no_frame", fs, 0);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vblank_scheduler.md
Name: vblank_scheduler

Overview:
- Frame-synchronous arbiter that shares the vertical-blanking window, taken from the VGA timing generator's vblnk, among N_REQ game-logic requesters (puck physics, paddle updates, score logic).
- Each requester gets an exclusive grant in round-robin order, so that frame-state updates happen only while the display is blanked.
- Sits between the timing generator and the game-logic blocks. It also provides a frame pulse, a frame counter and sticky error flags.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- SLOT_MAX, 1024, maximum cycles a single grant is held before a forced timeout (>=2).
- FCNT_W, 8, frame counter width.

Ports:
- clk_in  input  1  pixel clock, same as the timing generator.
- rst  input  1  synchronous reset, active-high.
- vblnk  input  1  vertical blank from the timing generator.
- req  input  N_REQ  per-requester update request, level.
- done  input  N_REQ  per-requester completion, sampled only for the granted index.
- err_clr  input  1  clears the sticky error flags.
- grant  output  N_REQ  one-hot grant, registered.
- busy  output  1  high in ARB and GRANT states.
- frame_start  output  1  one-cycle pulse per detected vblnk rise.
- frame_cnt  output  FCNT_W  count of vblnk rises, wraps modulo 2^FCNT_W.
- timeout_err  output  1  sticky: a grant hit SLOT_MAX.
- overrun_err  output  1  sticky: vblnk fell with work still granted or pending.

Behaviour:
- Reset:
  - grant=0, busy=0, frame_start=0, frame_cnt=0, timeout_err=0, overrun_err=0.
  - State=IDLE, pending=0, rr_ptr=0, slot_cnt=0.
  - vblnk_d resets to 1, so a reset mid-blank produces no frame until the next true rise.
  - Reset mid-grant drops grant on the next edge.
- Rise detect: rise = vblnk & ~vblnk_d; vblnk_d is registered every cycle.
- States: IDLE, ARB, GRANT, WAIT_END.
- IDLE:
  - On rise, at the same edge: frame_start<=1, frame_cnt<=frame_cnt+1, pending<=req, state<=ARB.
  - frame_start is 0 in every other cycle.
- ARB, checked in this order:
  - If vblnk=0: if pending!=0 set overrun_err; pending<=0; go IDLE.
  - Else if pending=0: go WAIT_END.
  - Else the winner is the first set pending bit at index >= rr_ptr, wrapping to 0. Set grant<=onehot(winner), slot_cnt<=0, go GRANT.
  - Latency: grant is first visible 2 cycles after the cycle where the rise is sampled.
- GRANT, checked in this priority order:
  - vblnk=0: grant<=0, overrun_err<=1, pending<=0, go IDLE.
  - done[winner]=1: grant<=0, clear pending[winner], rr_ptr<=(winner+1) mod N_REQ, go ARB.
  - slot_cnt==SLOT_MAX-1: same as done, plus timeout_err<=1.
  - Otherwise slot_cnt++.
  - Grant is high for at most SLOT_MAX cycles.
  - There is exactly one grant-low cycle between consecutive grants.
  - If done and timeout occur in the same cycle, done wins and no error is set.
- WAIT_END: go IDLE when vblnk=0. A rise cannot occur here.
- req changes after latching are ignored until the next frame; a requester not latched waits for the next frame.
- done bits on non-granted indices are ignored.
- rr_ptr persists across frames.
- err_clr clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- Widths:
  - slot_cnt is $clog2(SLOT_MAX) bits.
  - rr_ptr is $clog2(N_REQ) bits, minimum 1.
  - rr_ptr wrap is explicit, not a power-of-2 overflow.

Optional Feature:
- Macro: VBLANK_SCHED_FIXED_PRIO_EN.
- Defined: the winner is the lowest set pending index (index 0 highest priority); rr_ptr is unused and held at 0.
- Undefined: round-robin as described under Behaviour.

Test Plan:
1. Reset with vblnk=1 held, release rst, keep vblnk=1 for 100 cycles -> frame_start never pulses; frame_cnt=0; grant=0.
2. N_REQ=3, req=3'b111, vblnk 0->1, each requester asserts done 5 cycles after its grant -> frame_start pulses once; grants in order 001, 010, 100 with one grant-low gap between each; frame_cnt=1; WAIT_END reached; next frame with req=3'b011 grants 001 then 010; rr_ptr ends at 2.
3. SLOT_MAX=16, req=3'b010, done never asserted -> grant=010 for exactly 16 cycles, then grant=0 and timeout_err=1; err_clr pulse -> timeout_err=0.
4. req=3'b111, vblnk falls while grant=010 -> grant=0 on the next edge; overrun_err=1; state IDLE; pending cleared.
5. done and timeout in the same cycle at slot_cnt=SLOT_MAX-1 -> grant drops; timeout_err stays 0.
6. 256 vblnk rises with FCNT_W=8 -> frame_cnt wraps to 0. With VBLANK_SCHED_FIXED_PRIO_EN defined and req=3'b101 on two consecutive frames -> grant order is 001, 100 in both frames.
